// File: rtl/vec_lsu_pkg.sv
// Shared definitions for the strided vector load/store master.
//   sew_e    : element-width encodings carried on vsew
//   state_e  : command sequencer states
//   WSTRB_*  : unshifted byte-enable masks per element width
//   misaligned() : element alignment rule applied before each request
package vec_lsu_pkg;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    XFER  = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  function automatic logic misaligned(input logic [2:0] sew, input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (sew)
      SEW_16:  m = off[0];
      SEW_32:  m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vec_lane_align.sv
// Combinational byte-lane steering for one element.
//   vsew  : element width encoding
//   off   : byte offset of the element inside its 32-bit word
//   rdata : memory read word; elem is the selected lane, zero-extended
//   wsrc  : element to store (SEW bits in the LSBs); wdata is it replicated
//           across all lanes, wstrb enables only the element's bytes
module vec_lane_align
  import vec_lsu_pkg::*;
(
  input  logic [2:0]  vsew,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wsrc,
  output logic [31:0] elem,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    elem    = '0;
    wdata   = '0;
    wstrb   = '0;
    case (vsew)
      SEW_8: begin
        elem  = {24'h0, shifted[7:0]};
        wdata = {4{wsrc[7:0]}};
        wstrb = WSTRB_B << off;
      end
      SEW_16: begin
        elem  = {16'h0, shifted[15:0]};
        wdata = {2{wsrc[15:0]}};
        wstrb = WSTRB_H << off;
      end
      SEW_32: begin
        elem  = shifted;
        wdata = wsrc;
        wstrb = WSTRB_W;
      end
      default: begin
        elem  = '0;
        wdata = '0;
        wstrb = '0;
      end
    endcase
  end

endmodule

// File: rtl/vec_strided_mem_master.sv
// Strided vector load/store master: walks vl elements at base + i*stride,
// one single-beat memory request per element.
//   start/op_store/base/stride/vl/vsew : command, latched when idle
//   busy/done/err                      : command status
//   mem_*                              : valid/ready memory port (word addressed)
//   vrf_rd_idx/vrf_rd_data             : store element source
//   elem_we/elem_idx/elem_data         : loaded element sink
module vec_strided_mem_master
  import vec_lsu_pkg::*;
#(
  parameter int unsigned VL_W   = 9,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              op_store,
  input  logic [ADDR_W-1:0] base,
  input  logic [31:0]       stride,
  input  logic [VL_W-1:0]   vl,
  input  logic [2:0]        vsew,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic [VL_W-1:0]   vrf_rd_idx,
  input  logic [31:0]       vrf_rd_data,
  output logic              elem_we,
  output logic [VL_W-1:0]   elem_idx,
  output logic [31:0]       elem_data
);

  state_e            state, state_nx;
  logic              op_store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       stride_q;
  logic [VL_W-1:0]   vl_q, idx_q;
  logic [2:0]        vsew_q;
  logic              err_q;
  logic              elem_we_q;
  logic [VL_W-1:0]   elem_idx_q;
  logic [31:0]       elem_data_q;

  logic [ADDR_W-1:0] stride_ext;
  logic              misal, accept, last;
  logic [31:0]       lane_elem, lane_wdata;
  logic [3:0]        lane_wstrb;

  // Signed cast so negative strides sign-extend and the sum wraps mod 2^ADDR_W.
  assign stride_ext = ADDR_W'($signed(stride_q));
  assign misal      = misaligned(vsew_q, addr_q[1:0]);
  assign accept     = (state == XFER) && !misal && mem_ready;
  assign last       = (idx_q == vl_q - VL_W'(1));

  vec_lane_align u_lane (
    .vsew  (vsew_q),
    .off   (addr_q[1:0]),
    .rdata (mem_rdata),
    .wsrc  (vrf_rd_data),
    .elem  (lane_elem),
    .wdata (lane_wdata),
    .wstrb (lane_wstrb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   if ((vsew_q > SEW_32) || (vl_q == '0)) state_nx = FIN;
               else                                   state_nx = XFER;
      XFER:    if (misal || (mem_ready && last)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_store_q  <= 1'b0;
      addr_q      <= '0;
      stride_q    <= '0;
      vl_q        <= '0;
      idx_q       <= '0;
      vsew_q      <= '0;
      err_q       <= 1'b0;
      elem_we_q   <= 1'b0;
      elem_idx_q  <= '0;
      elem_data_q <= '0;
    end else begin
      elem_we_q <= accept && !op_store_q;
      if (state == IDLE && start) begin
        op_store_q <= op_store;
        addr_q     <= base;
        stride_q   <= stride;
        vl_q       <= vl;
        vsew_q     <= vsew;
        idx_q      <= '0;
        err_q      <= 1'b0;
      end
      if (state == CHECK && vsew_q > SEW_32) err_q <= 1'b1;
      if (state == XFER && misal)            err_q <= 1'b1;
      if (accept) begin
        addr_q <= addr_q + stride_ext;
        idx_q  <= idx_q + VL_W'(1);
        if (!op_store_q) begin
          elem_idx_q  <= idx_q;
          elem_data_q <= lane_elem;
        end
      end
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FIN);
    err        = (state == FIN) && err_q;
    mem_valid  = (state == XFER) && !misal;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    vrf_rd_idx = '0;
    if (state == XFER) begin
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (op_store_q) begin
        vrf_rd_idx = idx_q;
        mem_wdata  = lane_wdata;
        mem_wstrb  = lane_wstrb;
      end
    end
  end

  assign elem_we   = elem_we_q;
  assign elem_idx  = elem_idx_q;
  assign elem_data = elem_data_q;

endmodule

// File: tb/tb_vec_strided_mem_master.sv
module tb_vec_strided_mem_master;

  localparam int VL_W   = 9;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn, start, op_store;
  logic [ADDR_W-1:0] base;
  logic [31:0]       stride;
  logic [VL_W-1:0]   vl;
  logic [2:0]        vsew;
  logic              busy, done, err, mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, vrf_rd_data, elem_data;
  logic [3:0]        mem_wstrb;
  logic [VL_W-1:0]   vrf_rd_idx, elem_idx;
  logic              elem_we;

  logic [31:0] mem [0:255];
  logic [31:0] vrf [0:7];

  int total = 0;
  int bad   = 0;

  logic [31:0] got_data[$];
  int          got_idx[$];
  logic [31:0] acc_addr[$];
  logic [3:0]  acc_strb[$];
  logic [31:0] acc_wdata[$];
  int          viol;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_addr, prev_wdata;

  vec_strided_mem_master #(.VL_W(VL_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_store(op_store),
    .base(base), .stride(stride), .vl(vl), .vsew(vsew),
    .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .vrf_rd_idx(vrf_rd_idx), .vrf_rd_data(vrf_rd_data),
    .elem_we(elem_we), .elem_idx(elem_idx), .elem_data(elem_data)
  );

  always #5 clk = ~clk;

  assign mem_rdata   = mem[mem_addr[9:2]];
  assign vrf_rd_data = vrf[vrf_rd_idx[2:0]];

  // Responder: ready one cycle after an unanswered valid.
  always @(posedge clk) mem_ready <= mem_valid && !mem_ready;

  // Monitor and memory writes, sampled mid-cycle.
  always @(negedge clk) begin
    if (elem_we) begin
      got_data.push_back(elem_data);
      got_idx.push_back(int'(elem_idx));
    end
    if (mem_valid && mem_ready) begin
      acc_addr.push_back(mem_addr);
      acc_strb.push_back(mem_wstrb);
      acc_wdata.push_back(mem_wdata);
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
    if (resetn && prev_valid && !prev_ready &&
        (!mem_valid || mem_addr !== prev_addr || mem_wdata !== prev_wdata))
      viol++;
    prev_valid = mem_valid;
    prev_ready = mem_ready;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[100] = 32'h04030201;
    mem[101] = 32'h08070605;
    mem[102] = 32'h0c0b0a09;
    mem[103] = 32'h000f0e0d;
  endtask

  // Issues one command and waits for done; poke>0 re-pulses start with
  // unrelated parameters on that cycle to show it is ignored while busy.
  task automatic run_cmd(input logic st, input logic [31:0] bs, input logic [31:0] sd,
                         input int n, input logic [2:0] sew, input int poke,
                         output int lat, output logic e, output logic we_at_done);
    int cyc;
    got_data.delete(); got_idx.delete();
    acc_addr.delete(); acc_strb.delete(); acc_wdata.delete();
    viol = 0;
    @(negedge clk);
    op_store = st; base = bs; stride = sd; vl = VL_W'(n); vsew = sew; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (cyc == poke) begin
        start = 1'b1; op_store = 1'b1; base = 32'h0; vl = VL_W'(1); vsew = 3'b000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat = cyc; e = err; we_at_done = elem_we;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, err, mem_valid, elem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_status: got %b want 00000", {busy, done, err, mem_valid, elem_we});
    end
    total++;
    if (mem_addr !== '0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: got addr %h strb %h wdata %h want 0", mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_load_h(input int poke);
    logic [31:0] exp_d [4] = '{32'h0201, 32'h0605, 32'h0a09, 32'h0e0d};
    int lat; logic e, we;
    run_cmd(1'b0, 32'd400, 32'd4, 4, 3'b001, poke, lat, e, we);
    total++;
    if (got_data.size() != 4 || acc_addr.size() != 4) begin
      bad++;
      $display("FAIL load_h_count: got %0d elems %0d accesses want 4 4", got_data.size(), acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_data[i] !== exp_d[i] || got_idx[i] != i || acc_addr[i] !== 32'(400 + 4*i)) begin
          bad++;
          $display("FAIL load_h_elem%0d: got data %h idx %0d addr %0d want %h %0d %0d",
                   i, got_data[i], got_idx[i], acc_addr[i], exp_d[i], i, 400 + 4*i);
        end
      end
    end
    total++;
    if (e !== 1'b0 || we !== 1'b1 || viol != 0) begin
      bad++;
      $display("FAIL load_h_done: got err %b we_at_done %b viol %0d want 0 1 0", e, we, viol);
    end
  endtask

  task automatic test_load_b();
    int lat; logic e, we;
    run_cmd(1'b0, 32'd400, 32'd1, 4, 3'b000, 0, lat, e, we);
    total++;
    if (got_data.size() != 4 || acc_addr.size() != 4) begin
      bad++;
      $display("FAIL load_b_count: got %0d elems %0d accesses want 4 4", got_data.size(), acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_data[i] !== 32'(i + 1) || acc_addr[i] !== 32'd400 || acc_strb[i] !== 4'h0) begin
          bad++;
          $display("FAIL load_b_elem%0d: got data %h addr %0d strb %b want %h 400 0000",
                   i, got_data[i], acc_addr[i], acc_strb[i], i + 1);
        end
      end
    end
    total++;
    if (e !== 1'b0 || we !== 1'b1) begin
      bad++;
      $display("FAIL load_b_done: got err %b we_at_done %b want 0 1", e, we);
    end
  endtask

  task automatic test_load_w_neg();
    int lat; logic e, we;
    run_cmd(1'b0, 32'd412, -32'sd4, 2, 3'b010, 0, lat, e, we);
    total++;
    if (got_data.size() != 2 || got_data[0] !== 32'h000f0e0d || got_data[1] !== 32'h0c0b0a09) begin
      bad++;
      $display("FAIL load_w_neg_data: got %0d elems first %h want 2 000f0e0d 0c0b0a09",
               got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx);
    end
    total++;
    if (acc_addr.size() != 2 || acc_addr[0] !== 32'd412 || acc_addr[1] !== 32'd408) begin
      bad++;
      $display("FAIL load_w_neg_addr: got %0d accesses want 412 then 408", acc_addr.size());
    end
  endtask

  task automatic test_store();
    int lat; logic e, we;
    vrf[0] = 32'hAAAABEEF;
    vrf[1] = 32'h55551234;
    run_cmd(1'b1, 32'd600, 32'd2, 2, 3'b001, 0, lat, e, we);
    total++;
    if (mem[150] !== 32'h1234BEEF) begin
      bad++;
      $display("FAIL store_word: got %h want 1234beef", mem[150]);
    end
    total++;
    if (acc_strb.size() != 2 || acc_strb[0] !== 4'b0011 || acc_strb[1] !== 4'b1100 ||
        acc_wdata[0] !== 32'hBEEFBEEF || acc_wdata[1] !== 32'h12341234) begin
      bad++;
      $display("FAIL store_beats: got %0d beats want strb 0011/1100 wdata beefbeef/12341234", acc_strb.size());
    end
    total++;
    if (got_data.size() != 0 || e !== 1'b0 || viol != 0) begin
      bad++;
      $display("FAIL store_side: got %0d elem writes err %b viol %0d want 0 0 0", got_data.size(), e, viol);
    end
  endtask

  task automatic test_errors();
    int lat; logic e, we;
    run_cmd(1'b0, 32'd402, 32'd4, 3, 3'b010, 0, lat, e, we);
    total++;
    if (e !== 1'b1 || acc_addr.size() != 0 || got_data.size() != 0 || viol != 0) begin
      bad++;
      $display("FAIL misalign_first: got err %b accesses %0d elems %0d want 1 0 0", e, acc_addr.size(), got_data.size());
    end
    run_cmd(1'b0, 32'd400, 32'd4, 2, 3'b011, 0, lat, e, we);
    total++;
    if (e !== 1'b1 || lat != 2 || acc_addr.size() != 0) begin
      bad++;
      $display("FAIL bad_vsew: got err %b lat %0d accesses %0d want 1 2 0", e, lat, acc_addr.size());
    end
    run_cmd(1'b0, 32'd400, 32'd4, 0, 3'b000, 0, lat, e, we);
    total++;
    if (e !== 1'b0 || lat != 2 || acc_addr.size() != 0) begin
      bad++;
      $display("FAIL vl_zero: got err %b lat %0d accesses %0d want 0 2 0", e, lat, acc_addr.size());
    end
    // Second element at 403 is odd for 16-bit: first element kept, then stop.
    run_cmd(1'b0, 32'd400, 32'd3, 3, 3'b001, 0, lat, e, we);
    total++;
    if (e !== 1'b1 || acc_addr.size() != 1 || got_data.size() != 1 ||
        (got_data.size() == 1 && got_data[0] !== 32'h0201)) begin
      bad++;
      $display("FAIL misalign_mid: got err %b accesses %0d elems %0d want 1 1 1 (0201)",
               e, acc_addr.size(), got_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    int lat; logic e, we;
    @(negedge clk);
    op_store = 1'b0; base = 32'd400; stride = 32'd4; vl = VL_W'(4); vsew = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!elem_we && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (!elem_we || !mem_valid) begin
      bad++;
      $display("FAIL rst_mid_setup: got elem_we %b mem_valid %b want 1 1", elem_we, mem_valid);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({mem_valid, busy, elem_we} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_async: got valid/busy/we %b want 000", {mem_valid, busy, elem_we});
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_valid || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_no_resume: got %0d active cycles want 0", seen);
    end
    run_cmd(1'b0, 32'd404, 32'd4, 1, 3'b010, 0, lat, e, we);
    total++;
    if (got_data.size() != 1 || got_data[0] !== 32'h08070605 || e !== 1'b0 || we !== 1'b1) begin
      bad++;
      $display("FAIL rst_restart: got %0d elems err %b want 1 elem 08070605 err 0", got_data.size(), e);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op_store = 1'b0;
    base = '0; stride = '0; vl = '0; vsew = '0;
    for (int i = 0; i < 8; i++) vrf[i] = 32'h0;
    init_mem();
    test_reset();
    test_load_h(0);
    test_load_b();
    test_load_w_neg();
    test_store();
    test_errors();
    test_load_h(3);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_strided_mem_master.md
VEC_STRIDED_MEM_MASTER -- requirements
Module: vec_strided_mem_master

Interface
REQ-001 SHALL have parameter VL_W, default 9, meaning width of the vl and element-index fields.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle command strobe.
- op_store  in  1  0 = strided load, 1 = strided store.
- base  in  ADDR_W  byte address of element 0 (cpu rs1).
- stride  in  32  signed byte stride (cpu rs2).
- vl  in  VL_W  element count.
- vsew  in  3  000 = 8-bit, 001 = 16-bit, 010 = 32-bit elements.
- busy  out  1  command in progress.
- done  out  1  single-cycle completion pulse.
- err  out  1  single-cycle error pulse, coincident with done.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accept; rdata is valid in the same cycle.
- mem_addr  out  ADDR_W  word-aligned request address.
- mem_wdata  out  32  store data.
- mem_wstrb  out  4  byte enables; 0000 = read.
- mem_rdata  in  32  read data.
- vrf_rd_idx  out  VL_W  element index for the store data read.
- vrf_rd_data  in  32  element to store, combinational from vrf_rd_idx, SEW bits in the LSBs.
- elem_we  out  1  load-element write strobe.
- elem_idx  out  VL_W  index of the written element.
- elem_data  out  32  loaded element, zero-extended.

Function
REQ-004 SHALL accept start only in state IDLE; start while busy SHALL be ignored.
REQ-005 SHALL latch base, stride, vl, vsew and op_store on acceptance.
REQ-006 SHALL raise busy on the cycle after acceptance and hold it until done.
REQ-007 SHALL implement states IDLE -> CHECK -> XFER -> FIN -> IDLE.
REQ-008 SHALL, in CHECK, go to FIN with err if vsew > 010.
REQ-009 SHALL, in CHECK, go to FIN without err if vl = 0; no memory access occurs.
REQ-010 SHALL compute element address addr_i = base + i*stride by accumulation, modulo 2^ADDR_W, so negative strides wrap.
REQ-011 SHALL drive mem_addr = {addr_i[ADDR_W-1:2], 2'b00}.
REQ-012 SHALL check alignment before issuing each element; addr_i[0] set for 16-bit or addr_i[1:0] nonzero for 32-bit SHALL go to FIN with err.
REQ-013 SHALL not issue a misaligned element, SHALL keep prior elements written, and SHALL issue no further elements.
REQ-014 SHALL, in XFER, hold mem_valid high continuously with a stable address and data until mem_ready is sampled high.
REQ-015 SHALL, on the edge where mem_ready is sampled high, advance the index and address; the next element's request SHALL appear from that edge.
REQ-016 SHALL, for loads, take elem_data from mem_rdata byte lane addr_i[1:0] (zero-extended to 32 bits).
REQ-017 SHALL, for loads, pulse elem_we one cycle after that accepting edge, with elem_idx = i.
REQ-018 SHALL, for stores, drive vrf_rd_idx = i.
REQ-019 SHALL, for stores, drive mem_wdata = element replicated across lanes (8-bit x4, 16-bit x2).
REQ-020 SHALL, for stores, drive mem_wstrb = 0001<<off for 8-bit, 0011<<off for 16-bit, and 1111 for 32-bit, where off = addr_i[1:0].
REQ-021 SHALL, for loads, drive mem_wstrb = 0000.
REQ-022 SHALL go from XFER to FIN after element vl-1 is accepted.
REQ-023 SHALL, in FIN, pulse done (and err if flagged), drop busy and return to IDLE; done SHALL coincide with the last elem_we.

Reset
REQ-024 SHALL, on asynchronous resetn low, force state IDLE and all outputs to 0, including mid-transfer, with mem_valid dropping immediately.
REQ-025 SHALL issue no request until a new start after resetn is released.

Structure
REQ-026 SHALL place the vsew encodings, the state enum and the wstrb lane masks in shared package vec_lsu_pkg.
REQ-027 SHALL implement lane extract/replicate and wstrb generation in sub-module vec_lane_align, which is purely combinational.

Verification
Memory: word 100 = 0x04030201, 101 = 0x08070605, 102 = 0x0c0b0a09, 103 = 0x000f0e0d. Responder raises ready one cycle after valid && !ready.
REQ-028 Load, vsew = 001, base = 400, stride = 4, vl = 4 -> elem_data 0x0201, 0x0605, 0x0a09, 0x0e0d at idx 0..3, done with no err.
REQ-029 Load, vsew = 000, base = 400, stride = 1, vl = 4 -> 0x01..0x04, with mem_addr = 400 for all four requests.
REQ-030 Load, vsew = 010, base = 412, stride = -4, vl = 2 -> 0x000f0e0d then 0x0c0b0a09.
REQ-031 Store, vsew = 001, base = 600, stride = 2, vl = 2, vrf data 0xBEEF, 0x1234 -> word 150 = 0x1234BEEF; writes have wstrb 0011 then 1100.
REQ-032 vsew = 010, base = 402 -> err with done, mem_valid never asserted; vl = 0 -> done two cycles after start, no err.
REQ-033 resetn pulled low mid-XFER -> mem_valid, busy and elem_we are 0 immediately; a following start with vl = 1 completes normally.
